// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load-store requesters onto one memory port,
// one transaction in flight, with a starvation guard that forces fetch through.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic [XLEN/8-1:0] ls_be,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              fetch_stall,
  output logic              lsu_stall,
  output logic              protocol_err
);

  localparam int BEW = XLEN / 8;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_IF = 3'd1,
    ISSUE_LS = 3'd2,
    WAIT_IF  = 3'd3,
    WAIT_LS  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SCW-1:0]    r_starve;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [BEW-1:0]    r_mem_be;
  logic              r_if_gnt;
  logic              r_ls_gnt;
  logic              r_perr;

  logic              w_idle;
  logic              w_issue;
  logic              w_if_win;
  logic              w_ls_win;
  logic              w_if_hs;
  logic              w_ls_hs;
  logic              w_err;
  logic              w_if_resp;
  logic              w_ls_resp;

  assign w_idle    = (r_state == IDLE);
  assign w_issue   = (r_state == ISSUE_IF) || (r_state == ISSUE_LS);
  // Fetch normally yields to load-store unless it has been denied long enough.
  assign w_if_win  = w_idle && if_req && (!ls_req || (r_starve == STARVE_MAX));
  assign w_ls_win  = w_idle && ls_req && !w_if_win;
  assign w_if_hs   = (r_state == ISSUE_IF) && mem_ready;
  assign w_ls_hs   = (r_state == ISSUE_LS) && mem_ready;
  assign w_if_resp = (r_state == WAIT_IF) && mem_rvalid;
  assign w_ls_resp = (r_state == WAIT_LS) && mem_rvalid;
  assign w_err     = (mem_rvalid && (w_idle || w_issue)) ||
                     ((r_state == ISSUE_IF) && !if_req) ||
                     ((r_state == ISSUE_LS) && !ls_req);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_if_win) begin
          w_next = ISSUE_IF;
        end else if (w_ls_win) begin
          w_next = ISSUE_LS;
        end else begin
          w_next = IDLE;
        end
      end
      ISSUE_IF: begin
        if (mem_ready) w_next = WAIT_IF;
        else           w_next = ISSUE_IF;
      end
      ISSUE_LS: begin
        if (mem_ready) w_next = WAIT_LS;
        else           w_next = ISSUE_LS;
      end
      WAIT_IF: begin
        if (mem_rvalid) w_next = IDLE;
        else            w_next = WAIT_IF;
      end
      WAIT_LS: begin
        if (mem_rvalid) w_next = IDLE;
        else            w_next = WAIT_LS;
      end
      default: w_next = IDLE;
    endcase
  end

  // Memory request fields: captured at arbitration, held through ISSUE, cleared on acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (w_if_win) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= if_addr;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (w_ls_win) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= ls_we;
      r_mem_addr  <= ls_addr;
      r_mem_wdata <= ls_wdata;
      r_mem_be    <= ls_be;
    end else if (w_if_hs || w_ls_hs) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end
  end

  // Single-cycle grant pulses, visible in the first WAIT cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_if_gnt <= 1'b0;
      r_ls_gnt <= 1'b0;
    end else begin
      r_if_gnt <= w_if_hs;
      r_ls_gnt <= w_ls_hs;
    end
  end

  // Starvation counter: counts fetch losses, saturates, cleared when fetch is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_starve <= '0;
    end else if (w_if_hs) begin
      r_starve <= '0;
    end else if (w_ls_win && if_req && (r_starve != STARVE_MAX)) begin
      r_starve <= r_starve + SCW'(1);
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= r_perr | w_err;
    end
  end

  // Responses route straight through to the owning requester only.
  always_comb begin
    if_rdata = '0;
    ls_rdata = '0;
    if (w_if_resp) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = '0;
    end
    if (w_ls_resp) begin
      ls_rdata = mem_rdata;
    end else begin
      ls_rdata = '0;
    end
  end

  assign if_rvalid    = w_if_resp;
  assign ls_rvalid    = w_ls_resp;
  assign if_gnt       = r_if_gnt;
  assign ls_gnt       = r_ls_gnt;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_be       = r_mem_be;
  assign protocol_err = r_perr;
  // Stalls are masked while in reset so every output reads 0 there.
  assign fetch_stall  = rstn & if_req & ~r_if_gnt;
  assign lsu_stall    = rstn & ls_req & ~r_ls_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for starvation, spurious responses, request drop and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fetch_stall, lsu_stall, protocol_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fetch_stall(fetch_stall), .lsu_stall(lsu_stall), .protocol_err(protocol_err)
  );

  typedef struct packed {
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        fetch_stall;
    logic        lsu_stall;
    logic        protocol_err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];

  function automatic in_t mk_i(logic rs, logic ir, logic [31:0] ia, logic lr, logic lw,
                               logic [31:0] la, logic [31:0] lwd, logic [3:0] lb,
                               logic rdy, logic rv, logic [31:0] rd);
    in_t v;
    v.rstn = rs; v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw;
    v.ls_addr = la; v.ls_wdata = lwd; v.ls_be = lb; v.mem_ready = rdy;
    v.mem_rvalid = rv; v.mem_rdata = rd;
    return v;
  endfunction

  function automatic out_t mk_o(logic ig, logic iv, logic [31:0] ird, logic lg, logic lv,
                                logic [31:0] lrd, logic mr, logic mw, logic [31:0] ma,
                                logic [31:0] mwd, logic [3:0] mb, logic fs, logic ls,
                                logic er);
    out_t v;
    v.if_gnt = ig; v.if_rvalid = iv; v.if_rdata = ird; v.ls_gnt = lg; v.ls_rvalid = lv;
    v.ls_rdata = lrd; v.mem_req = mr; v.mem_we = mw; v.mem_addr = ma; v.mem_wdata = mwd;
    v.mem_be = mb; v.fetch_stall = fs; v.lsu_stall = ls; v.protocol_err = er;
    return v;
  endfunction

  function automatic out_t sample();
    return mk_o(if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_req, mem_we,
                mem_addr, mem_wdata, mem_be, fetch_stall, lsu_stall, protocol_err);
  endfunction

  task automatic add(in_t i, out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  task automatic apply(in_t v);
    rstn = v.rstn; if_req = v.if_req; if_addr = v.if_addr; ls_req = v.ls_req;
    ls_we = v.ls_we; ls_addr = v.ls_addr; ls_wdata = v.ls_wdata; ls_be = v.ls_be;
    mem_ready = v.mem_ready; mem_rvalid = v.mem_rvalid; mem_rdata = v.mem_rdata;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic chk_out(string nm, out_t got, out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    apply(mk_i(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0));
    next_cycle();
    rstn = 1'b1;
  endtask

  out_t z;
  logic seq_got[6];
  logic seq_exp[6];
  int   ng;
  logic last_g;

  initial begin
    apply(mk_i(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0));
    z = mk_o(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
             1'b0, 1'b0, 1'b0);

    // reset, then a single fetch
    add(mk_i(0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,32'h0), z);
    add(mk_i(1,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,32'h0), z);
    add(mk_i(1,1,32'h100,0,0,32'h0,32'h0,4'h0,0,0,32'h0),
        mk_o(0,0,32'h0,0,0,32'h0,0,0,32'h0,32'h0,4'h0,1,0,0));
    add(mk_i(1,1,32'h100,0,0,32'h0,32'h0,4'h0,1,0,32'h0),
        mk_o(0,0,32'h0,0,0,32'h0,1,0,32'h100,32'h0,4'h0,1,0,0));
    add(mk_i(1,1,32'h100,0,0,32'h0,32'h0,4'h0,0,0,32'h0),
        mk_o(1,0,32'h0,0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,0));
    add(mk_i(1,0,32'h0,0,0,32'h0,32'h0,4'h0,0,1,32'hDEADBEEF),
        mk_o(0,1,32'hDEADBEEF,0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,0));
    add(mk_i(1,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,32'h0), z);
    // simultaneous requests: store wins first, then fetch
    add(mk_i(1,1,32'h300,1,1,32'h200,32'hA5A5A5A5,4'hF,0,0,32'h0),
        mk_o(0,0,32'h0,0,0,32'h0,0,0,32'h0,32'h0,4'h0,1,1,0));
    add(mk_i(1,1,32'h300,1,1,32'h200,32'hA5A5A5A5,4'hF,1,0,32'h0),
        mk_o(0,0,32'h0,0,0,32'h0,1,1,32'h200,32'hA5A5A5A5,4'hF,1,1,0));
    add(mk_i(1,1,32'h300,1,1,32'h200,32'hA5A5A5A5,4'hF,0,0,32'h0),
        mk_o(0,0,32'h0,1,0,32'h0,0,0,32'h0,32'h0,4'h0,1,0,0));
    add(mk_i(1,1,32'h300,0,0,32'h0,32'h0,4'h0,0,1,32'h12345678),
        mk_o(0,0,32'h0,0,1,32'h12345678,0,0,32'h0,32'h0,4'h0,1,0,0));
    add(mk_i(1,1,32'h300,0,0,32'h0,32'h0,4'h0,0,0,32'h0),
        mk_o(0,0,32'h0,0,0,32'h0,0,0,32'h0,32'h0,4'h0,1,0,0));
    add(mk_i(1,1,32'h300,0,0,32'h0,32'h0,4'h0,1,0,32'h0),
        mk_o(0,0,32'h0,0,0,32'h0,1,0,32'h300,32'h0,4'h0,1,0,0));
    add(mk_i(1,1,32'h300,0,0,32'h0,32'h0,4'h0,0,1,32'hCAFEF00D),
        mk_o(1,1,32'hCAFEF00D,0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,0));
    add(mk_i(1,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,32'h0), z);
    // store held in ISSUE_LS by mem_ready low for 5 cycles
    add(mk_i(1,0,32'h0,1,1,32'h400,32'h0BADCAFE,4'h3,0,0,32'h0),
        mk_o(0,0,32'h0,0,0,32'h0,0,0,32'h0,32'h0,4'h0,0,1,0));
    for (int k = 0; k < 5; k++) begin
      add(mk_i(1,0,32'h0,1,1,32'hFFF,32'h0BADCAFE,4'h3,0,0,32'h0),
          mk_o(0,0,32'h0,0,0,32'h0,1,1,32'h400,32'h0BADCAFE,4'h3,0,1,0));
    end
    add(mk_i(1,0,32'h0,1,1,32'hFFF,32'h0BADCAFE,4'h3,1,0,32'h0),
        mk_o(0,0,32'h0,0,0,32'h0,1,1,32'h400,32'h0BADCAFE,4'h3,0,1,0));
    add(mk_i(1,0,32'h0,1,1,32'hFFF,32'h0BADCAFE,4'h3,0,0,32'h0),
        mk_o(0,0,32'h0,1,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,0));
    add(mk_i(1,0,32'h0,0,0,32'h0,32'h0,4'h0,0,1,32'h0),
        mk_o(0,0,32'h0,0,1,32'h0,0,0,32'h0,32'h0,4'h0,0,0,0));
    add(mk_i(1,0,32'h0,0,0,32'h0,32'h0,4'h0,0,0,32'h0), z);

    for (int r = 0; r < vecs.size(); r++) begin
      next_cycle();
      apply(vecs[r].i);
      @(negedge clk);
      chk_out($sformatf("vec%0d", r), sample(), vecs[r].o);
    end

    // starvation: four load-store grants, then fetch, then load-store again
    do_reset();
    if_req = 1'b1; if_addr = 32'h700; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h800;
    mem_ready = 1'b1;
    seq_exp[0] = 1'b0; seq_exp[1] = 1'b0; seq_exp[2] = 1'b0; seq_exp[3] = 1'b0;
    seq_exp[4] = 1'b1; seq_exp[5] = 1'b0;
    ng = 0;
    last_g = 1'b0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      next_cycle();
      mem_rvalid = last_g;
      @(negedge clk);
      last_g = if_gnt | ls_gnt;
      if (if_gnt) begin
        seq_got[ng] = 1'b1;
        ng++;
      end else if (ls_gnt) begin
        seq_got[ng] = 1'b0;
        ng++;
      end
    end
    chk("starve_grant_count", 32'(ng), 32'd6);
    for (int g = 0; g < ng; g++) begin
      chk($sformatf("starve_grant%0d_is_fetch", g), {31'h0, seq_got[g]}, {31'h0, seq_exp[g]});
    end
    chk("starve_no_err", {31'h0, protocol_err}, 32'h0);

    // spurious response in IDLE
    do_reset();
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    @(negedge clk);
    chk("spur_no_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk($sformatf("spur_err_sticky%0d", k), {31'h0, protocol_err}, 32'h1);
    end
    do_reset();
    @(negedge clk);
    chk("spur_err_cleared", {31'h0, protocol_err}, 32'h0);

    // fetch drops its request in ISSUE: error flagged, transaction completes
    next_cycle();
    if_req = 1'b1; if_addr = 32'h500;
    next_cycle();
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("drop_issue_req", {31'h0, mem_req}, 32'h1);
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("drop_err", {31'h0, protocol_err}, 32'h1);
    chk("drop_addr", mem_addr, 32'h500);
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("drop_gnt", {31'h0, if_gnt}, 32'h1);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("drop_rdata", if_rdata, 32'h55AA55AA);
    chk("drop_rvalid", {31'h0, if_rvalid}, 32'h1);

    // reset while in WAIT_IF, late response afterwards
    do_reset();
    if_req = 1'b1; if_addr = 32'h600;
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_wait_gnt", {31'h0, if_gnt}, 32'h1);
    next_cycle();
    rstn = 1'b0;
    @(negedge clk);
    chk_out("rst_outputs_zero", sample(), z);
    next_cycle();
    rstn = 1'b1; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    chk("rst_late_no_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_late_err", {31'h0, protocol_err}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
